// File: rtl/emu_clock_sched_pkg.sv
// rtl/emu_clock_sched_pkg.sv - shared types, default widths and helpers for the clock scheduler
package emu_clock_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_PRESENT = 2'd2
    } sched_state_t;

    localparam int DEF_NUM_CLK  = 4;
    localparam int DEF_PERIOD_W = 32;
    localparam int DEF_TIME_W   = 64;
    localparam int DEF_STEP_W   = 32;

    // Index width never collapses to zero for a single-clock build.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/emu_clock_min_select.sv
// rtl/emu_clock_min_select.sv - combinational earliest-edge search with tie mask
module emu_clock_min_select #(
    parameter int NUM_CLK = 4,
    parameter int TIME_W  = 64
) (
    input  logic [NUM_CLK-1:0][TIME_W-1:0] edges,
    input  logic [NUM_CLK-1:0]             enable,
    output logic [TIME_W-1:0]              min_time,
    output logic [NUM_CLK-1:0]             min_mask,
    output logic                           any_en
);

    logic [TIME_W-1:0] best;
    logic              found;

    always_comb begin
        best  = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_CLK; i++) begin
            if (enable[i] && (!found || (edges[i] < best))) begin
                best  = edges[i];
                found = 1'b1;
            end
        end
    end

    // Every enabled clock sharing the earliest time edges together.
    always_comb begin
        min_mask = '0;
        for (int i = 0; i < NUM_CLK; i++) begin
            min_mask[i] = enable[i] && (edges[i] == best);
        end
    end

    assign min_time = best;
    assign any_en   = |enable;

endmodule

// File: rtl/emu_clock_scheduler.sv
// rtl/emu_clock_scheduler.sv - steps emulated time from one earliest clock edge to the next
module emu_clock_scheduler
    import emu_clock_sched_pkg::*;
#(
    parameter int NUM_CLK  = DEF_NUM_CLK,
    parameter int PERIOD_W = DEF_PERIOD_W,
    parameter int TIME_W   = DEF_TIME_W,
    parameter int STEP_W   = DEF_STEP_W,
    localparam int IDX_W   = idx_w(NUM_CLK)
) (
    input  logic                host_clk,
    input  logic                host_rst,
    input  logic                cfg_wen,
    input  logic [IDX_W-1:0]    cfg_idx,
    input  logic [PERIOD_W-1:0] cfg_period,
    input  logic [PERIOD_W-1:0] cfg_phase,
    input  logic                start,
    input  logic [STEP_W-1:0]   step_count,
    input  logic                stop,
    output logic                busy,
    output logic                done,
    output logic                tick_valid,
    input  logic                tick_ready,
    output logic [NUM_CLK-1:0]  tick_mask,
    output logic [TIME_W-1:0]   tick_time,
    output logic [TIME_W-1:0]   cur_time
);

    sched_state_t state, state_next;

    logic [PERIOD_W-1:0]             period [NUM_CLK];
    logic [NUM_CLK-1:0][TIME_W-1:0]  next_edge;
    logic [NUM_CLK-1:0]              clk_en;
    logic [TIME_W-1:0]               min_time;
    logic [NUM_CLK-1:0]              min_mask;
    logic                            any_en;
    logic [STEP_W-1:0]               remaining;
    logic                            stop_pend;
    logic                            run_end;
    logic                            handshake;
    logic                            cfg_hit;

    always_comb begin
        clk_en = '0;
        for (int i = 0; i < NUM_CLK; i++) begin
            clk_en[i] = (period[i] != '0);
        end
    end

    emu_clock_min_select #(
        .NUM_CLK (NUM_CLK),
        .TIME_W  (TIME_W)
    ) u_min_select (
        .edges    (next_edge),
        .enable   (clk_en),
        .min_time (min_time),
        .min_mask (min_mask),
        .any_en   (any_en)
    );

    assign handshake = (state == ST_PRESENT) && tick_ready;
    assign cfg_hit   = cfg_wen && (state == ST_IDLE) && (32'(cfg_idx) < NUM_CLK);
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge host_clk or posedge host_rst) begin
        if (host_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // run_end marks every path back to IDLE from a start, abort or final tick.
    always_comb begin
        state_next = state;
        run_end    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if ((step_count == '0) || !any_en) begin
                        run_end = 1'b1;
                    end else begin
                        state_next = ST_COMPUTE;
                    end
                end
            end
            ST_COMPUTE: begin
                if (stop || stop_pend) begin
                    state_next = ST_IDLE;
                    run_end    = 1'b1;
                end else begin
                    state_next = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (tick_ready) begin
                    if ((remaining == STEP_W'(1)) || stop || stop_pend) begin
                        state_next = ST_IDLE;
                        run_end    = 1'b1;
                    end else begin
                        state_next = ST_COMPUTE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge host_clk or posedge host_rst) begin
        if (host_rst) begin
            done       <= 1'b0;
            tick_valid <= 1'b0;
            tick_mask  <= '0;
            tick_time  <= '0;
            cur_time   <= '0;
            remaining  <= '0;
            stop_pend  <= 1'b0;
            next_edge  <= '0;
            for (int i = 0; i < NUM_CLK; i++) begin
                period[i] <= '0;
            end
        end else begin
            done <= run_end;

            if (state_next == ST_IDLE) begin
                stop_pend <= 1'b0;
            end else if (stop) begin
                stop_pend <= 1'b1;
            end

            if (cfg_hit) begin
                period[cfg_idx]    <= cfg_period;
                next_edge[cfg_idx] <= cur_time + TIME_W'(cfg_phase);
            end

            if ((state == ST_IDLE) && (state_next == ST_COMPUTE)) begin
                remaining <= step_count;
            end

            if ((state == ST_COMPUTE) && (state_next == ST_PRESENT)) begin
                tick_valid <= 1'b1;
                tick_time  <= min_time;
                tick_mask  <= min_mask;
            end

            if (handshake) begin
                tick_valid <= 1'b0;
                cur_time   <= tick_time;
                remaining  <= remaining - STEP_W'(1);
                for (int i = 0; i < NUM_CLK; i++) begin
                    if (tick_mask[i]) begin
                        next_edge[i] <= next_edge[i] + TIME_W'(period[i]);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_emu_clock_scheduler.sv
// tb/tb_emu_clock_scheduler.sv - scoreboard bench for emu_clock_scheduler
module tb_emu_clock_scheduler;

    logic        host_clk;
    logic        host_rst;
    logic        cfg_wen;
    logic [1:0]  cfg_idx;
    logic [31:0] cfg_period;
    logic [31:0] cfg_phase;
    logic        start;
    logic [31:0] step_count;
    logic        stop;
    logic        busy;
    logic        done;
    logic        tick_valid;
    logic        tick_ready;
    logic [3:0]  tick_mask;
    logic [63:0] tick_time;
    logic [63:0] cur_time;

    emu_clock_scheduler dut (
        .host_clk   (host_clk),
        .host_rst   (host_rst),
        .cfg_wen    (cfg_wen),
        .cfg_idx    (cfg_idx),
        .cfg_period (cfg_period),
        .cfg_phase  (cfg_phase),
        .start      (start),
        .step_count (step_count),
        .stop       (stop),
        .busy       (busy),
        .done       (done),
        .tick_valid (tick_valid),
        .tick_ready (tick_ready),
        .tick_mask  (tick_mask),
        .tick_time  (tick_time),
        .cur_time   (cur_time)
    );

    typedef struct {
        logic [3:0]  mask;
        logic [63:0] t;
    } tick_t;

    tick_t       exp_q[$];
    int          checks;
    int          errors;
    int          acc_cnt;
    bit          ready_rand;
    logic        ready_val;
    logic [31:0] m_period [4];
    logic [63:0] m_next [4];
    logic [63:0] m_cur;

    initial begin
        host_clk = 1'b0;
        forever #5 host_clk = ~host_clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        tick_ready = 1'b1;
        forever begin
            @(posedge host_clk);
            #2;
            tick_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_val;
        end
    end

    // Monitor: scoreboard pops on each accepted tick and checks held ticks stay put.
    initial begin
        tick_t       e;
        logic        hold;
        logic [3:0]  hm;
        logic [63:0] ht;
        hold = 1'b0;
        hm   = '0;
        ht   = '0;
        forever begin
            @(negedge host_clk);
            if (host_rst) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    chk("hold_valid", 64'(tick_valid), 64'd1);
                    chk("hold_mask", 64'(tick_mask), 64'(hm));
                    chk("hold_time", tick_time, ht);
                end
                if (tick_valid && tick_ready) begin
                    acc_cnt++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_tick: got time %0d mask %0d expected no tick", tick_time, tick_mask);
                    end else begin
                        e = exp_q.pop_front();
                        chk("tick_mask", 64'(tick_mask), 64'(e.mask));
                        chk("tick_time", tick_time, e.t);
                    end
                end
                hold = tick_valid && !tick_ready;
                hm   = tick_mask;
                ht   = tick_time;
            end
        end
    end

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            m_period[i] = '0;
            m_next[i]   = '0;
        end
        m_cur = '0;
        exp_q.delete();
    endtask

    function automatic bit model_any();
        for (int i = 0; i < 4; i++) begin
            if (m_period[i] != 0) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Reference: earliest pending edge among running clocks, all ties edge together.
    task automatic predict(input int n);
        logic [63:0] t;
        logic [3:0]  mk;
        if (n == 0 || !model_any()) return;
        repeat (n) begin
            t = '1;
            for (int i = 0; i < 4; i++) begin
                if (m_period[i] != 0 && m_next[i] < t) t = m_next[i];
            end
            mk = '0;
            for (int i = 0; i < 4; i++) begin
                if (m_period[i] != 0 && m_next[i] == t) mk[i] = 1'b1;
            end
            exp_q.push_back('{mk, t});
            for (int i = 0; i < 4; i++) begin
                if (mk[i]) m_next[i] = m_next[i] + 64'(m_period[i]);
            end
            m_cur = t;
        end
    endtask

    task automatic do_reset();
        host_rst = 1'b1;
        @(posedge host_clk); #1;
        @(posedge host_clk); #1;
        host_rst = 1'b0;
        model_clear();
    endtask

    task automatic cfg(input int idx, input logic [31:0] p, input logic [31:0] ph, input bit model);
        cfg_wen    = 1'b1;
        cfg_idx    = 2'(idx);
        cfg_period = p;
        cfg_phase  = ph;
        if (model) begin
            m_period[idx] = p;
            m_next[idx]   = m_cur + 64'(ph);
        end
        @(posedge host_clk); #1;
        cfg_wen = 1'b0;
    endtask

    task automatic start_run(input int steps);
        step_count = 32'(steps);
        start      = 1'b1;
        @(posedge host_clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge host_clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk("done_seen", 64'(seen), 64'd1);
        @(posedge host_clk); #1;
        chk("idle_after_done", 64'(busy), 64'd0);
    endtask

    task automatic wait_valid(input bit need_ready);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge host_clk);
            if (tick_valid && (!need_ready || tick_ready)) begin
                seen = 1'b1;
                break;
            end
        end
        chk("valid_seen", 64'(seen), 64'd1);
        @(posedge host_clk); #1;
    endtask

    task automatic run_full(input int steps);
        bit nop;
        nop = (steps == 0) || !model_any();
        predict(steps);
        start_run(steps);
        if (nop) begin
            chk("nop_done", 64'(done), 64'd1);
            chk("nop_busy", 64'(busy), 64'd0);
            @(negedge host_clk);
            chk("nop_no_tick", 64'(tick_valid), 64'd0);
            @(posedge host_clk); #1;
        end else begin
            wait_done(steps * 60 + 20);
        end
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        chk("cur_time", cur_time, m_cur);
    endtask

    initial begin
        #3_000_000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        int a0;
        checks     = 0;
        errors     = 0;
        acc_cnt    = 0;
        ready_rand = 1'b0;
        ready_val  = 1'b1;
        host_rst   = 1'b1;
        cfg_wen    = 1'b0;
        cfg_idx    = '0;
        cfg_period = '0;
        cfg_phase  = '0;
        start      = 1'b0;
        step_count = '0;
        stop       = 1'b0;
        model_clear();
        @(negedge host_clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_valid", 64'(tick_valid), 64'd0);
        chk("rst_mask", 64'(tick_mask), 64'd0);
        chk("rst_tick_time", tick_time, 64'd0);
        chk("rst_cur_time", cur_time, 64'd0);
        @(posedge host_clk); #1;
        do_reset();

        // Single clock, three steps.
        cfg(0, 32'd10000, 32'd0, 1'b1);
        run_full(3);
        chk("single_cur_time", cur_time, 64'd20000);

        // Two clocks with coincident edges.
        do_reset();
        cfg(0, 32'd10000, 32'd0, 1'b1);
        cfg(1, 32'd15000, 32'd0, 1'b1);
        run_full(5);
        chk("dual_cur_time", cur_time, 64'd30000);

        // Backpressure for seven cycles.
        ready_val = 1'b0;
        a0 = acc_cnt;
        predict(1);
        start_run(1);
        wait_valid(1'b0);
        for (int i = 0; i < 7; i++) begin
            chk("hold_busy", 64'(busy), 64'd1);
            @(posedge host_clk); #1;
        end
        chk("hold_not_accepted", 64'(acc_cnt - a0), 64'd0);
        ready_val = 1'b1;
        wait_done(20);
        chk("hold_accepted", 64'(acc_cnt - a0), 64'd1);
        chk("hold_cur_time", cur_time, m_cur);

        // Stop while computing the second of ten ticks.
        a0 = acc_cnt;
        predict(1);
        start_run(10);
        wait_valid(1'b1);
        stop = 1'b1;
        @(posedge host_clk); #1;
        stop = 1'b0;
        chk("stop_compute_done", 64'(done), 64'd1);
        chk("stop_compute_busy", 64'(busy), 64'd0);
        @(posedge host_clk); #1;
        chk("stop_compute_ticks", 64'(acc_cnt - a0), 64'd1);
        chk("stop_compute_cur", cur_time, m_cur);

        // Stop while a tick is held; it still completes.
        ready_val = 1'b0;
        a0 = acc_cnt;
        predict(1);
        start_run(10);
        wait_valid(1'b0);
        stop = 1'b1;
        @(posedge host_clk); #1;
        stop = 1'b0;
        ready_val = 1'b1;
        wait_done(20);
        chk("stop_present_ticks", 64'(acc_cnt - a0), 64'd1);
        chk("stop_present_cur", cur_time, m_cur);

        // Zero step budget.
        run_full(0);

        // Config writes while busy are ignored.
        ready_val = 1'b0;
        predict(2);
        start_run(2);
        cfg(0, 32'd777, 32'd5, 1'b0);
        cfg(2, 32'd1234, 32'd0, 1'b0);
        ready_val = 1'b1;
        wait_done(40);
        run_full(4);

        // No enabled clocks.
        do_reset();
        run_full(5);

        // Randomized configurations and backpressure.
        ready_rand = 1'b1;
        for (int it = 0; it < 25; it++) begin
            if (it % 5 == 0) do_reset();
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 3) != 0) begin
                    cfg(i, ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 40000)),
                        32'($urandom_range(0, 40000)), 1'b1);
                end
            end
            run_full(int'($urandom_range(0, 12)));
        end
        ready_rand = 1'b0;
        ready_val  = 1'b1;

        // Reset while a tick is presented.
        do_reset();
        cfg(0, 32'd10000, 32'd3000, 1'b1);
        cfg(3, 32'd7000, 32'd0, 1'b1);
        run_full(3);
        ready_val = 1'b0;
        start_run(4);
        wait_valid(1'b0);
        host_rst = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(tick_valid), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_cur", cur_time, 64'd0);
        chk("mid_rst_mask", 64'(tick_mask), 64'd0);
        @(posedge host_clk); #1;
        host_rst = 1'b0;
        model_clear();
        ready_val = 1'b1;
        run_full(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
